roundkey_store: RTL and testbench

ROUNDKEY_STORE -- requirements
Module: roundkey_store

---
 rtl/aes_pkg.sv | 17 +
 rtl/roundkey_store.sv | 125 ++++++++++++
 tb/tb_roundkey_store.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants, size helpers and the round-key store FSM state type.
package aes_pkg;

  localparam int WORD = 32;
  localparam int NB   = 4;

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic int tw_of(input int nk, input int nb);
    return nb * (nr_of(nk) + 1);
  endfunction

endpackage

// File: rtl/roundkey_store.sv
// Captures an expanded AES key schedule word by word and serves whole round keys.
// Reads have 1-cycle latency; o_ready is high only while loading, with no further backpressure.
module roundkey_store #(
  parameter int WORD = aes_pkg::WORD,
  parameter int NB   = aes_pkg::NB,
  parameter int NK   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_valid,
  input  logic [WORD-1:0]    i_word,
  output logic               o_ready,
  input  logic               i_rd_en,
  input  logic [3:0]         i_rd_idx,
  output logic [NB*WORD-1:0] o_rk,
  output logic               o_rk_valid,
  output logic               o_rd_err,
  output logic               o_done
);
  import aes_pkg::*;

  localparam int NR = nr_of(NK);
  localparam int TW = tw_of(NK, NB);
  localparam int KW = NB * WORD;
  localparam int CW = $clog2(TW);
  localparam int RW = $clog2(NR + 1);
  localparam logic [3:0] NR_IDX = 4'(NR);

  state_t        state;
  logic [CW-1:0] wcnt;
  logic [KW-1:0] pack;
  logic [KW-1:0] mem [NR+1];

  int            lane;
  logic [RW-1:0] round;
  logic          accept;
  logic          last_lane;
  logic          last_word;
  logic [KW-1:0] key_full;

  always_comb begin
    lane      = int'(wcnt) % NB;
    round     = RW'(int'(wcnt) / NB);
    accept    = (state == LOAD) && i_valid && !i_start;
    last_lane = (lane == NB - 1);
    last_word = (wcnt == CW'(TW - 1));
    // The last lane sits in the low word, so the finished key bypasses the pack register.
    key_full  = {pack[KW-1:WORD], i_word};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      pack    <= '0;
      o_ready <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (i_start) begin
            state   <= LOAD;
            wcnt    <= '0;
            pack    <= '0;
            o_ready <= 1'b1;
            o_done  <= 1'b0;
          end
        end
        LOAD: begin
          if (i_start) begin
            wcnt <= '0;
            pack <= '0;
          end else if (i_valid) begin
            for (int l = 0; l < NB; l++) begin
              if (lane == l) pack[KW-1-l*WORD -: WORD] <= i_word;
            end
            if (last_word) begin
              state   <= READY;
              o_ready <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r <= NR; r++) mem[r] <= '0;
    end else if (accept && last_lane) begin
      mem[round] <= key_full;
    end
  end

  // Reads are only honoured once READY is registered, so a read alongside the final write is rejected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_rk       <= '0;
      o_rk_valid <= 1'b0;
      o_rd_err   <= 1'b0;
    end else begin
      o_rk_valid <= 1'b0;
      o_rd_err   <= 1'b0;
      if (i_rd_en) begin
        if (state == READY && i_rd_idx <= NR_IDX) begin
          o_rk       <= mem[i_rd_idx];
          o_rk_valid <= 1'b1;
        end else begin
          o_rk     <= '0;
          o_rd_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_roundkey_store.sv
// Directed-plus-random bench for roundkey_store with an AES key-expansion reference model.
module tb_roundkey_store;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, valid, rd_en, sel8;
  logic [31:0]  word;
  logic [3:0]   rd_idx;
  logic [127:0] rk4, rk8, rk;
  logic         rdy4, rdy8, rdy, rv4, rv8, rv, er4, er8, er, dn4, dn8, dn;

  roundkey_store #(.NK(4)) dut4 (
    .clk(clk), .rst(rst), .i_start(start & ~sel8), .i_valid(valid & ~sel8), .i_word(word),
    .o_ready(rdy4), .i_rd_en(rd_en & ~sel8), .i_rd_idx(rd_idx), .o_rk(rk4),
    .o_rk_valid(rv4), .o_rd_err(er4), .o_done(dn4)
  );

  roundkey_store #(.NK(8)) dut8 (
    .clk(clk), .rst(rst), .i_start(start & sel8), .i_valid(valid & sel8), .i_word(word),
    .o_ready(rdy8), .i_rd_en(rd_en & sel8), .i_rd_idx(rd_idx), .o_rk(rk8),
    .o_rk_valid(rv8), .o_rd_err(er8), .o_done(dn8)
  );

  assign rk  = sel8 ? rk8  : rk4;
  assign rdy = sel8 ? rdy8 : rdy4;
  assign rv  = sel8 ? rv8  : rv4;
  assign er  = sel8 ? er8  : er4;
  assign dn  = sel8 ? dn8  : dn4;

  localparam logic [127:0] SB [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  int           checks = 0;
  int           errors = 0;
  logic [31:0]  wbuf   [60];
  logic [127:0] ref_rk [16];

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    row = SB[b[7:4]];
    return row[127 - 8 * int'(b[3:0]) -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // FIPS-197 key expansion into wbuf; the key is left-aligned in 256 bits.
  task automatic expand(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        wbuf[i] = key[255 - 32 * i -: 32];
      end else begin
        t = wbuf[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        wbuf[i] = wbuf[i-nk] ^ t;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rd(input int idx);
    rd_en  = 1'b1;
    rd_idx = 4'(idx);
    tick();
    rd_en  = 1'b0;
  endtask

  // Feeds words a..b with random idle gaps; the model records each completed round key.
  task automatic load_range(input int a, input int b, input bit read_last);
    for (int i = a; i <= b; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      valid = 1'b1;
      word  = wbuf[i];
      if (read_last && i == b) begin
        rd_en  = 1'b1;
        rd_idx = 4'd0;
      end
      tick();
      valid = 1'b0;
      rd_en = 1'b0;
      if (i % 4 == 3) ref_rk[i/4] = {wbuf[i-3], wbuf[i-2], wbuf[i-1], wbuf[i]};
      if (read_last && i == b) begin
        chk("last_write_read_err", er, 1);
        chk("last_write_read_vld", rv, 0);
      end
    end
  endtask

  task automatic check_all(input string tag, input int nr);
    for (int r = 0; r <= nr; r++) begin
      rd(r);
      chk($sformatf("%s_vld%0d", tag, r), rv, 1);
      chk($sformatf("%s_rk%0d", tag, r), rk, ref_rk[r]);
    end
  endtask

  task automatic rand_key(output logic [255:0] k);
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [255:0] key;
    rst = 1'b0; start = 1'b0; valid = 1'b0; rd_en = 1'b0; sel8 = 1'b0;
    word = '0; rd_idx = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("reset_rk", rk, 0);
    chk("reset_rk_valid", rv, 0);
    chk("reset_rd_err", er, 0);
    chk("reset_done", dn, 0);
    chk("reset_ready", rdy, 0);

    // Words offered while idle are ignored and reads are rejected.
    for (int i = 0; i < 4; i++) begin
      valid = 1'(i % 2);
      word  = $urandom;
      tick();
    end
    valid = 1'b0;
    chk("idle_ready", rdy, 0);
    chk("idle_done", dn, 0);
    rd(0);
    chk("idle_read_err", er, 1);
    chk("idle_read_vld", rv, 0);

    // AES-128 FIPS-197 schedule with a read during LOAD and one alongside the final write.
    expand(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    do_start();
    chk("load_ready", rdy, 1);
    chk("load_done", dn, 0);
    load_range(0, 19, 1'b0);
    rd(0);
    chk("load_read_err", er, 1);
    chk("load_read_vld", rv, 0);
    chk("load_read_rk", rk, 0);
    load_range(20, 43, 1'b1);
    chk("fips_done", dn, 1);
    chk("fips_ready", rdy, 0);
    check_all("fips", 10);
    rd(0);
    chk("fips_key0", rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd(10);
    chk("fips_key10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(11);
    chk("idx11_err", er, 1);
    chk("idx11_vld", rv, 0);
    chk("idx11_rk", rk, 0);
    rd(3);
    tick();
    chk("hold_vld", rv, 0);
    chk("hold_rk", rk, ref_rk[3]);
    chk("hold_err", er, 0);

    // Random i_valid traffic in READY must leave the store untouched.
    for (int i = 0; i < 20; i++) begin
      valid = 1'($urandom_range(0, 1));
      word  = $urandom;
      tick();
    end
    valid = 1'b0;
    chk("ready_ignore_done", dn, 1);
    chk("ready_ignore_rdy", rdy, 0);
    check_all("ready_ignore", 10);

    // Abort after 17 words (restart collides with a valid word), then a full reload.
    rand_key(key);
    expand(4, {key[255:128], 128'h0});
    do_start();
    chk("restart_done_fall", dn, 0);
    load_range(0, 16, 1'b0);
    start = 1'b1;
    valid = 1'b1;
    word  = $urandom;
    tick();
    start = 1'b0;
    valid = 1'b0;
    chk("abort_done", dn, 0);
    chk("abort_ready", rdy, 1);
    rand_key(key);
    expand(4, {key[255:128], 128'h0});
    load_range(0, 43, 1'b0);
    chk("reload_done", dn, 1);
    check_all("reload", 10);

    // Reset mid-LOAD.
    rand_key(key);
    expand(4, {key[255:128], 128'h0});
    do_start();
    load_range(0, 9, 1'b0);
    rst = 1'b0;
    #2;
    chk("mid_rst_ready", rdy, 0);
    chk("mid_rst_done", dn, 0);
    chk("mid_rst_vld", rv, 0);
    chk("mid_rst_err", er, 0);
    chk("mid_rst_rk", rk, 0);
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      word  = $urandom;
      tick();
    end
    valid = 1'b0;
    chk("post_rst_ready", rdy, 0);
    chk("post_rst_done", dn, 0);
    rd(0);
    chk("post_rst_read_err", er, 1);
    do_start();
    load_range(0, 43, 1'b0);
    chk("post_rst_load_done", dn, 1);
    check_all("post_rst", 10);

    // NK=8 instance: 60 words, idx 14 valid, idx 15 rejected.
    sel8 = 1'b1;
    tick();
    rand_key(key);
    expand(8, key);
    do_start();
    load_range(0, 58, 1'b0);
    chk("nk8_done_before_last", dn, 0);
    chk("nk8_ready_before_last", rdy, 1);
    load_range(59, 59, 1'b0);
    chk("nk8_done", dn, 1);
    check_all("nk8", 14);
    rd(15);
    chk("nk8_idx15_err", er, 1);
    chk("nk8_idx15_vld", rv, 0);
    chk("nk8_idx15_rk", rk, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
